// File: rtl/async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl
//
// Read-domain controller for the dual-clock FIFO. It brings the write Gray
// pointer into rd_clk through a SYNC_STAGES flop chain. It keeps the read
// binary and Gray pointers and drives the synchronous-read RAM port. It also
// produces the user-facing status: empty, almost_empty, level and a sticky
// underflow. The partner write-domain controller owns full and shares reset.
//
// Build option:
//   ASYNC_FIFO_RD_FWFT_EN  undefined -> standard mode. rd_en fetches a word
//                                       and rd_valid follows one cycle later.
//                          defined   -> first-word-fall-through mode. The
//                                       head word is presented without rd_en,
//                                       and rd_en consumes it.
//
// Handshake: the user may raise rd_en at any time. A word is transferred when
// rd_en is high while empty is low. In standard mode, the word appears on
// rd_data with rd_valid high on the following cycle. In FWFT mode, rd_data is
// already valid (rd_valid high) when rd_en is sampled. rd_en while empty
// transfers nothing and sets underflow.
//
// Ports:
//   rd_clk, reset    read clock; asynchronous active-high reset
//   wr_gray_ptr      write Gray pointer (registered in the wr_clk domain)
//   rd_en            read request
//   mem_rd_data      RAM output: valid the cycle after mem_rd_en, then held
//   rd_gray_ptr      registered read Gray pointer, sent to the write domain
//   mem_rd_en        RAM read strobe
//   mem_rd_addr      RAM read address (low bits of the binary read pointer)
//   rd_data          read data (straight from the RAM output register)
//   rd_valid         rd_data is valid
//   empty            no word available to the user
//   almost_empty     rd_level <= AE_THRESH
//   rd_level         user-visible occupancy, 0..DEPTH
//   underflow        sticky: rd_en seen while empty
//   state_dbg        output-stage state (1 = OUT_VALID); constant 0 in
//                    standard mode, which has no FSM
// -----------------------------------------------------------------------------
module async_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_gray_ptr,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH:0]   rd_gray_ptr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow,
    output logic                  state_dbg
);

    localparam int PW = ADDR_WIDTH + 1;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // ------------------------------------------------------------------ sync
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_gray_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];
    assign wq_bin  = gray2bin(wq_gray);

    // -------------------------------------------------------- read pointers
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic          ram_empty;
    logic [PW-1:0] ram_level;

    assign rd_bin_next = rd_bin + PW'(1);
    assign ram_empty   = (rd_gray_ptr == wq_gray);
    // The subtraction is modulo 2**PW, so the level stays correct across wraps.
    assign ram_level   = wq_bin - rd_bin;
    assign mem_rd_addr = rd_bin[ADDR_WIDTH-1:0];
    assign rd_data     = mem_rd_data;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_bin      <= '0;
            rd_gray_ptr <= '0;
        end else if (mem_rd_en) begin
            rd_bin      <= rd_bin_next;
            rd_gray_ptr <= rd_bin_next ^ (rd_bin_next >> 1);
        end
    end

`ifdef ASYNC_FIFO_RD_FWFT_EN
    // ------------------------------------------------------ FWFT out stage
    // The RAM output register doubles as the head-of-queue slot. OUT_VALID
    // means it holds an unconsumed word. Consuming the word and refilling the
    // slot happen on the same edge, so the FIFO sustains one word per cycle.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    out_state_t state, state_next;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (!ram_empty) begin
                    mem_rd_en  = 1'b1;
                    state_next = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (rd_en && !ram_empty) begin
                    mem_rd_en = 1'b1;
                end else if (rd_en) begin
                    state_next = OUT_EMPTY;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    assign rd_valid  = (state == OUT_VALID);
    assign empty     = ~rd_valid;
    assign rd_level  = ram_level + PW'(rd_valid);
    assign state_dbg = (state == OUT_VALID);
`else
    // ------------------------------------------------------ standard mode
    logic rd_valid_q;

    assign mem_rd_en = rd_en & ~ram_empty;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= mem_rd_en;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign empty     = ram_empty;
    assign rd_level  = ram_level;
    assign state_dbg = 1'b0;
`endif

    assign almost_empty = (rd_level <= PW'(AE_THRESH));

    // ------------------------------------------------------------ underflow
    // The pointer is left untouched on underflow. Only reset clears the flag.
    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (rd_en && empty) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_rd_ctrl
//
// Bench for the FIFO read-domain controller. It includes a small RAM model
// with a synchronous read port, and a behavioural reference for the FIFO.
// The reference tracks words written and words fetched as plain integers, and
// keeps every written word in exp_q. The write pointer reaches the read side
// after SYNC_STAGES clock edges; the reference models this with a history
// queue. Inputs change 1 ns after each rising edge, and outputs are sampled
// at that same point.
// -----------------------------------------------------------------------------
module tb_async_fifo_rd_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int AE    = 2;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          rd_clk      = 1'b0;
    logic          reset       = 1'b1;
    logic [PW-1:0] wr_gray_ptr = '0;
    logic          rd_en       = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;
    logic [PW-1:0] rd_gray_ptr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;
    logic          underflow;
    logic          state_dbg;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .AE_THRESH  (AE)
    ) dut (
        .rd_clk      (rd_clk),
        .reset       (reset),
        .wr_gray_ptr (wr_gray_ptr),
        .rd_en       (rd_en),
        .mem_rd_data (mem_rd_data),
        .rd_gray_ptr (rd_gray_ptr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_level    (rd_level),
        .underflow   (underflow),
        .state_dbg   (state_dbg)
    );

    // ------------------------------------------------ clock / RAM model
    always #5 rd_clk = ~rd_clk;

    logic [DW-1:0] ram [DEPTH];

    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    // ------------------------------------------------ reference model
    int            checks   = 0;
    int            failures = 0;
    int            wr_cnt;      // words written so far
    int            rd_cnt;      // words fetched out of the RAM so far
    bit            m_valid;     // a fetched word is presented to the user
    bit            m_uflow;
    logic [DW-1:0] exp_q[$];    // every written word, in write order
    int            hist[$];     // wr_cnt seen at each recent clock edge

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic int visible();
        return hist[hist.size() - SS];
    endfunction

    function automatic int m_level();
`ifdef ASYNC_FIFO_RD_FWFT_EN
        return visible() - rd_cnt + int'(m_valid);
`else
        return visible() - rd_cnt;
`endif
    endfunction

    function automatic bit m_empty();
`ifdef ASYNC_FIFO_RD_FWFT_EN
        return !m_valid;
`else
        return visible() == rd_cnt;
`endif
    endfunction

    task automatic model_reset();
        wr_cnt  = 0;
        rd_cnt  = 0;
        m_valid = 1'b0;
        m_uflow = 1'b0;
        exp_q.delete();
        hist.delete();
        repeat (SS) hist.push_back(0);
    endtask

    // ------------------------------------------------ driver tasks
    task automatic do_reset();
        reset       = 1'b1;
        rd_en       = 1'b0;
        wr_gray_ptr = '0;
        model_reset();
        @(posedge rd_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        ram[wr_cnt % DEPTH] = d;
        exp_q.push_back(d);
        wr_cnt++;
        wr_gray_ptr = to_gray(wr_cnt);
    endtask

    function automatic bit can_write();
        return (wr_cnt - rd_cnt) < DEPTH;
    endfunction

    // Advances one clock edge. The reference decides from pre-edge state.
    task automatic tick();
        bit ram_has;
        bit fetch;
        ram_has = (visible() != rd_cnt);
`ifdef ASYNC_FIFO_RD_FWFT_EN
        if (rd_en && !m_valid) m_uflow = 1'b1;
        fetch   = (!m_valid || rd_en) && ram_has;
        m_valid = fetch || (m_valid && !rd_en);
`else
        if (rd_en && !ram_has) m_uflow = 1'b1;
        fetch   = rd_en && ram_has;
        m_valid = fetch;
`endif
        if (fetch) rd_cnt++;
        @(posedge rd_clk);
        hist.push_back(wr_cnt);
        if (hist.size() > SS) void'(hist.pop_front());
        #1;
    endtask

    // ------------------------------------------------ tests
    task automatic test_reset();
        model_reset();
        @(posedge rd_clk);
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", rd_level); end
        checks++; if (rd_gray_ptr !== '0) begin failures++; $display("FAIL reset_gray got=%b exp=0", rd_gray_ptr); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
        reset = 1'b0;
    endtask

    task automatic test_first_word();
        do_reset();
        write_word(8'hA5);
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL first_empty_edge1 got=%b exp=1", empty); end
        tick();
        checks++; if (rd_level !== PW'(1)) begin failures++; $display("FAIL first_level got=%0d exp=1", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL first_almost_empty got=%b exp=1", almost_empty); end
`ifdef ASYNC_FIFO_RD_FWFT_EN
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL first_valid_edge2 got=%b exp=0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL first_valid_edge3 got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL first_data got=%h exp=a5", rd_data); end
`else
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL first_empty_edge2 got=%b exp=0", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL first_data got=%h exp=a5", rd_data); end
`endif
    endtask

`ifdef ASYNC_FIFO_RD_FWFT_EN
    task automatic test_fwft();
        do_reset();
        write_word(8'h5A);
        write_word(8'hC3);
        tick();
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL fwft_valid_early got=%b exp=0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL fwft_valid_rise got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 8'h5A) begin failures++; $display("FAIL fwft_word0 got=%h exp=5a", rd_data); end
        checks++; if (rd_level !== PW'(2)) begin failures++; $display("FAIL fwft_level2 got=%0d exp=2", rd_level); end
        rd_en = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin failures++; $display("FAIL fwft_word1 got=%b/%h exp=1/c3", rd_valid, rd_data); end
        checks++; if (rd_level !== PW'(1)) begin failures++; $display("FAIL fwft_level1 got=%0d exp=1", rd_level); end
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL fwft_drained got=%b/%b exp=0/1", rd_valid, empty); end
        checks++; if (rd_level !== '0) begin failures++; $display("FAIL fwft_level0 got=%0d exp=0", rd_level); end
    endtask
`else
    task automatic test_std_burst();
        logic [DW-1:0] wd [3];
        logic [PW-1:0] eg [3];
        wd = '{8'h11, 8'h22, 8'h33};
        eg = '{5'b00001, 5'b00011, 5'b00010};
        do_reset();
        for (int i = 0; i < 3; i++) write_word(wd[i]);
        tick();
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_rd_addr !== AW'(i)) begin failures++; $display("FAIL burst_addr%0d got=%0d exp=%0d", i, mem_rd_addr, i); end
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== wd[i]) begin failures++; $display("FAIL burst_data%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, wd[i]); end
            checks++; if (rd_gray_ptr !== eg[i]) begin failures++; $display("FAIL burst_gray%0d got=%b exp=%b", i, rd_gray_ptr, eg[i]); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL burst_empty got=%b exp=1", empty); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL burst_valid_fall got=%b exp=0", rd_valid); end
    endtask
`endif

    task automatic test_underflow();
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_gray_ptr !== '0) begin failures++; $display("FAIL uflow_gray got=%b exp=0", rd_gray_ptr); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uflow_set got=%b exp=1", underflow); end
        repeat (10) tick();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uflow_sticky got=%b exp=1", underflow); end
    endtask

    task automatic test_wrap();
        int            budget;
        bit            saw_wrap;
        logic [PW-1:0] prev_g;
        do_reset();
        budget   = 0;
        saw_wrap = 1'b0;
        prev_g   = '0;
        while (rd_cnt < 40 && budget < 400) begin
            rd_en = ($urandom_range(0, 3) != 0);
            if (wr_cnt < 40 && can_write() && $urandom_range(0, 3) != 0) write_word(DW'($urandom_range(0, 255)));
            tick();
            budget++;
            checks++; if (rd_gray_ptr !== to_gray(rd_cnt)) begin failures++; $display("FAIL wrap_gray n=%0d got=%b exp=%b", rd_cnt, rd_gray_ptr, to_gray(rd_cnt)); end
            if (rd_cnt == 32 && !saw_wrap) begin
                saw_wrap = 1'b1;
                checks++; if (prev_g !== 5'b10000 || rd_gray_ptr !== 5'b00000) begin failures++; $display("FAIL wrap_31_to_0 got=%b->%b exp=10000->00000", prev_g, rd_gray_ptr); end
            end
            prev_g = rd_gray_ptr;
        end
        checks++; if (!saw_wrap || rd_cnt < 40) begin failures++; $display("FAIL wrap_timeout got=%0d exp=40", rd_cnt); end
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            write_word(DW'($urandom_range(0, 255)));
            tick();
        end
        repeat (3) tick();
        checks++; if (rd_level !== PW'(16)) begin failures++; $display("FAIL wrap_level16 got=%0d exp=16", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL wrap_ae_clear got=%b exp=0", almost_empty); end
        budget = 0;
        while (m_level() > 2 && budget < 64) begin
            rd_en = 1'b1;
            tick();
            budget++;
        end
        rd_en = 1'b0;
        tick();
        checks++; if (rd_level !== PW'(2)) begin failures++; $display("FAIL wrap_level2 got=%0d exp=2", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL wrap_ae_set got=%b exp=1", almost_empty); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) write_word(DW'(8'h40 + i));
        repeat (3) tick();
        rd_en = 1'b1;
        repeat (2) tick();
        reset       = 1'b1;
        rd_en       = 1'b0;
        wr_gray_ptr = '0;
        model_reset();
        #1;
        checks++; if (rd_gray_ptr !== '0) begin failures++; $display("FAIL mid_async_gray got=%b exp=0", rd_gray_ptr); end
        @(posedge rd_clk);
        #1;
        checks++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL mid_empty_valid got=%b/%b exp=1/0", empty, rd_valid); end
        checks++; if (rd_level !== '0) begin failures++; $display("FAIL mid_level got=%0d exp=0", rd_level); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL mid_underflow got=%b exp=0", underflow); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int wp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            wp    = ((c / 100) % 2 == 0) ? 75 : 25;
            rd_en = ($urandom_range(0, 99) < 60);
            if (can_write() && $urandom_range(0, 99) < wp) write_word(DW'($urandom_range(0, 255)));
            tick();
            checks++; if (empty !== m_empty()) begin failures++; $display("FAIL rand_empty c=%0d got=%b exp=%b", c, empty, m_empty()); end
            checks++; if (rd_level !== PW'(m_level())) begin failures++; $display("FAIL rand_level c=%0d got=%0d exp=%0d", c, rd_level, m_level()); end
            checks++; if (almost_empty !== (m_level() <= AE)) begin failures++; $display("FAIL rand_ae c=%0d got=%b exp=%b", c, almost_empty, (m_level() <= AE)); end
            checks++; if (rd_valid !== m_valid) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, rd_valid, m_valid); end
            if (m_valid) begin
                checks++; if (rd_data !== exp_q[rd_cnt-1]) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, rd_data, exp_q[rd_cnt-1]); end
            end
            checks++; if (underflow !== m_uflow) begin failures++; $display("FAIL rand_underflow c=%0d got=%b exp=%b", c, underflow, m_uflow); end
            checks++; if (rd_gray_ptr !== to_gray(rd_cnt)) begin failures++; $display("FAIL rand_gray c=%0d got=%b exp=%b", c, rd_gray_ptr, to_gray(rd_cnt)); end
            checks++; if (mem_rd_addr !== AW'(rd_cnt % DEPTH)) begin failures++; $display("FAIL rand_addr c=%0d got=%0d exp=%0d", c, mem_rd_addr, rd_cnt % DEPTH); end
        end
        rd_en = 1'b0;
    endtask

    // ------------------------------------------------ sequence / report
    initial begin
        test_reset();
        test_first_word();
`ifdef ASYNC_FIFO_RD_FWFT_EN
        test_fwft();
`else
        test_std_burst();
`endif
        test_underflow();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
